// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: six-state one-hot T-state ring plus opcode/flag decode into the control word.
// Loads and counts are qualified by advance so a held T-state never repeats a strobe.
module sap_control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       cp,
  output logic       lp,
  output logic       lm,
  output logic       ri,
  output logic       li,
  output logic       la,
  output logic       lb,
  output logic       lo,
  output logic       ep,
  output logic       ce,
  output logic       ei,
  output logic       ea,
  output logic       eu,
  output logic       su
);

  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_STA = 4'h7;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state, state_nxt;
  logic   step_q;
  logic   advance;
  logic   strobe_en;
  logic   cp_d, lp_d, lm_d, ri_d, li_d, la_d, lb_d, lo_d;

  assign advance   = run | (step & ~step_q);
  // Reset abandons the current instruction, so its strobes are suppressed in the reset cycle too.
  assign strobe_en = advance & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_T1;
      step_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_q <= step;
    end
  end

  always_comb begin
    state_nxt = state;
    cp_d = 1'b0; lp_d = 1'b0; lm_d = 1'b0; ri_d = 1'b0;
    li_d = 1'b0; la_d = 1'b0; lb_d = 1'b0; lo_d = 1'b0;
    ep = 1'b0; ce = 1'b0; ei = 1'b0; ea = 1'b0; eu = 1'b0; su = 1'b0;

    if (advance) begin
      case (state)
        S_T1:    state_nxt = S_T2;
        S_T2:    state_nxt = S_T3;
        S_T3:    state_nxt = S_T4;
        S_T4:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_T5;
        S_T5:    state_nxt = S_T6;
        S_T6:    state_nxt = S_T1;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_T1;
      endcase
    end

    case (state)
      S_T1: begin ep = 1'b1; lm_d = 1'b1; end
      S_T2: cp_d = 1'b1;
      S_T3: begin ce = 1'b1; li_d = 1'b1; end
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin ei = 1'b1; lm_d = 1'b1; end
          OP_JMP: begin ei = 1'b1; lp_d = 1'b1; end
          OP_JC:  begin ei = flag_c; lp_d = flag_c; end
          OP_JZ:  begin ei = flag_z; lp_d = flag_z; end
          OP_LDI: begin ei = 1'b1; la_d = 1'b1; end
          OP_OUT: begin ea = 1'b1; lo_d = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA:         begin ce = 1'b1; la_d = 1'b1; end
          OP_ADD, OP_SUB: begin ce = 1'b1; lb_d = 1'b1; end
          OP_STA:         begin ea = 1'b1; ri_d = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          eu   = 1'b1;
          la_d = 1'b1;
          su   = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign cp = cp_d & strobe_en;
  assign lp = lp_d & strobe_en;
  assign lm = lm_d & strobe_en;
  assign ri = ri_d & strobe_en;
  assign li = li_d & strobe_en;
  assign la = la_d & strobe_en;
  assign lb = lb_d & strobe_en;
  assign lo = lo_d & strobe_en;

  assign t_state = state;
  assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: directed scenarios then random stimulus, all checked against a T-count micro-op model.
module tb_sap_control_sequencer;

  logic       clk = 1'b0;
  logic       rst, run, step, flag_c, flag_z;
  logic [3:0] opcode;
  logic [5:0] t_state;
  logic       halted, cp, lp, lm, ri, li, la, lb, lo, ep, ce, ei, ea, eu, su;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z), .t_state(t_state), .halted(halted),
    .cp(cp), .lp(lp), .lm(lm), .ri(ri), .li(li), .la(la), .lb(lb), .lo(lo),
    .ep(ep), .ce(ce), .ei(ei), .ea(ea), .eu(eu), .su(su)
  );

  localparam logic [13:0] M_CP = 14'h2000, M_LP = 14'h1000, M_LM = 14'h0800, M_RI = 14'h0400;
  localparam logic [13:0] M_LI = 14'h0200, M_LA = 14'h0100, M_LB = 14'h0080, M_LO = 14'h0040;
  localparam logic [13:0] M_EP = 14'h0020, M_CE = 14'h0010, M_EI = 14'h0008, M_EA = 14'h0004;
  localparam logic [13:0] M_EU = 14'h0002, M_SU = 14'h0001;
  localparam logic [13:0] STROBES = 14'h3FC0;

  int checks = 0;
  int errors = 0;
  int m_t    = 0;   // 1..6 = T-state number, 0 = halted
  bit m_sq   = 1'b0;
  bit m_valid = 1'b0;
  int cp_cnt = 0;
  int t_chg  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Micro-operations for T-state number t, straight from the instruction table.
  function automatic logic [13:0] micro(input int t, input logic [3:0] op, input logic fc, input logic fz);
    logic [13:0] w;
    w = '0;
    case (t)
      1: w = M_EP | M_LM;
      2: w = M_CP;
      3: w = M_CE | M_LI;
      4: begin
        if (op inside {4'h0, 4'h1, 4'h2, 4'h7}) w = M_EI | M_LM;
        else if (op == 4'h3 || (op == 4'h4 && fc) || (op == 4'h5 && fz)) w = M_EI | M_LP;
        else if (op == 4'h6) w = M_EI | M_LA;
        else if (op == 4'hE) w = M_EA | M_LO;
      end
      5: begin
        if (op == 4'h0) w = M_CE | M_LA;
        else if (op == 4'h1 || op == 4'h2) w = M_CE | M_LB;
        else if (op == 4'h7) w = M_EA | M_RI;
      end
      6: begin
        if (op == 4'h1) w = M_EU | M_LA;
        else if (op == 4'h2) w = M_EU | M_LA | M_SU;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic cycle(input logic r, input logic ru, input logic st, input logic [3:0] op,
                       input logic fc, input logic fz);
    logic        adv;
    logic [13:0] exp_w;
    logic [5:0]  t_before;
    rst = r; run = ru; step = st; opcode = op; flag_c = fc; flag_z = fz;
    @(negedge clk);
    adv = ru | (st & ~m_sq);
    t_before = t_state;
    if (m_valid) begin
      exp_w = (m_t == 0) ? 14'h0 : micro(m_t, op, fc, fz);
      if (!(adv && !r)) exp_w = exp_w & ~STROBES;
      check("t_state", t_state, (m_t == 0) ? 6'b0 : 6'(1 << (m_t - 1)));
      check("halted", halted, (m_t == 0));
      check("ctrl", {cp, lp, lm, ri, li, la, lb, lo, ep, ce, ei, ea, eu, su}, exp_w);
      check("bus_onehot", ($countones({ep, ce, ei, ea, eu}) <= 1), 1'b1);
    end
    if (cp === 1'b1) cp_cnt++;
    @(posedge clk);
    if (r) begin
      m_t = 1; m_sq = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_sq = st;
      if (m_t != 0 && adv) begin
        if (m_t == 4 && op == 4'hF) m_t = 0;
        else m_t = (m_t % 6) + 1;
      end
    end
    #1;
    if (t_state !== t_before) t_chg++;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, op, fc, fz);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;

    // Reset with run held high, then first post-reset cycle
    cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    rst = 1'b0; run = 1'b1; opcode = 4'h1;
    #1;
    check("rst_t_state", t_state, 6'b000001);
    check("rst_halted", halted, 1'b0);
    check("rst_ep_lm", {ep, lm}, 2'b11);

    run_instr(4'h1, 1'b0, 1'b0);
    check("add_wrap_t1", t_state, 6'b000001);
    run_instr(4'h2, 1'b0, 1'b0);
    run_instr(4'h5, 1'b0, 1'b0);
    run_instr(4'h5, 1'b0, 1'b1);
    run_instr(4'h4, 1'b0, 1'b1);
    run_instr(4'h4, 1'b1, 1'b0);
    for (int op = 0; op < 15; op++) run_instr(4'(op), 1'b1, 1'b1);

    // Single step: high 5, low 3, high 1 -> exactly two advances
    cycle(1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    cp_cnt = 0; t_chg = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    check("step_t_state", t_state, 6'b000100);
    check("step_cp_count", cp_cnt, 1);
    check("step_advances", t_chg, 2);

    // HLT, then run/step pulses while halted, then reset out
    cycle(1'b1, 1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, 1'b1);
    check("hlt_halted", halted, 1'b1);
    check("hlt_t_state", t_state, 6'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'(i % 3 == 0), 1'(i % 2), 4'(i), 1'b1, 1'b1);
    check("hlt_still_halted", halted, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    check("hlt_rst_t_state", t_state, 6'b000001);
    check("hlt_rst_halted", halted, 1'b0);

    // Reset during T5 of ADD
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    rst = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'h1;
    #1;
    check("midrst_la_lb", {la, lb}, 2'b00);
    cycle(1'b1, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
    check("midrst_t1", t_state, 6'b000001);
    run_instr(4'h1, 1'b0, 1'b0);

    // Random stimulus against the model
    begin
      logic [3:0] cur_op;
      cur_op = 4'h0;
      for (int i = 0; i < 4000; i++) begin
        if (m_t == 1) cur_op = 4'($urandom_range(0, 15));
        cycle(1'($urandom_range(0, 119) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)), cur_op,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
